mem_test_sequencer: RTL and testbench

//  Top-level test sequencer of the memory checker. On a CSR start it clears the measurement block,

---
 rtl/mem_test_sequencer_pkg.sv | 40 ++++
 rtl/mem_test_sequencer_if.sv | 43 ++++
 rtl/mem_test_sequencer_seq_watchdog.sv | 35 +++
 rtl/mem_test_sequencer.sv | 119 +++++++++++
 tb/tb_mem_test_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_test_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_test_sequencer_pkg                                                     |
// | Shared types and result indices for the memory-checker test sequencer.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mem_test_sequencer_pkg;

  localparam int CSR_WR_TICKS = 0;
  localparam int CSR_RD_REQ   = 7;

  typedef logic [CSR_RD_REQ:CSR_WR_TICKS][31:0] meas_results_t;

  typedef enum logic [1:0] {
    MODE_WR_ONLY    = 2'd0,
    MODE_RD_ONLY    = 2'd1,
    MODE_WR_THEN_RD = 2'd2,
    MODE_RSVD       = 2'd3
  } test_mode_t;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_TIMEOUT  = 3'd1,
    ST_ABORT    = 3'd2,
    ST_GEN_ERR  = 3'd3,
    ST_CFG_ERR  = 3'd4
  } test_status_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WR_RUN = 3'd2,
    S_RD_RUN = 3'd3,
    S_DRAIN  = 3'd4,
    S_SNAP   = 3'd5,
    S_DONE   = 3'd6
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_test_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_test_sequencer_if                                                      |
// | CSR, generator and measurement signals around the test sequencer.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mem_test_sequencer_if
  import mem_test_sequencer_pkg::*;
#(
  parameter int TMO_W = 32
);
  logic              csr_start_i;
  logic              csr_abort_i;
  test_mode_t        csr_mode_i;
  logic [TMO_W-1:0]  csr_timeout_i;
  logic              test_start_o;
  logic              gen_start_o;
  logic              gen_op_o;
  logic              gen_stop_o;
  logic              gen_done_i;
  logic              gen_error_i;
  logic              meas_busy_i;
  meas_results_t     meas_result_i;
  meas_results_t     result_o;
  logic              busy_o;
  logic              done_o;
  test_status_t      status_o;

  modport slave (
    input  csr_start_i, csr_abort_i, csr_mode_i, csr_timeout_i,
    input  gen_done_i, gen_error_i, meas_busy_i, meas_result_i,
    output test_start_o, gen_start_o, gen_op_o, gen_stop_o,
    output result_o, busy_o, done_o, status_o
  );

  modport master (
    output csr_start_i, csr_abort_i, csr_mode_i, csr_timeout_i,
    output gen_done_i, gen_error_i, meas_busy_i, meas_result_i,
    input  test_start_o, gen_start_o, gen_op_o, gen_stop_o,
    input  result_o, busy_o, done_o, status_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_test_sequencer_seq_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_test_sequencer_seq_watchdog                                            |
// | Per-phase load/enable/expire down-counter; a load value of 0 disables it.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_test_sequencer_seq_watchdog #(
  parameter int TMO_W = 32
) (
  input  wire             clk_i,
  input  wire             rst_i,
  input  wire             i_load,
  input  wire [TMO_W-1:0] i_load_val,
  input  wire             i_en,
  output logic            o_expire
);
  localparam logic [TMO_W-1:0] c_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_ONE;
    end
  end

  // Expiry is flagged in the cycle whose decrement takes the count to zero.
  assign o_expire = i_en && (r_cnt == c_ONE);

endmodule
`default_nettype wire

// File: rtl/mem_test_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_test_sequencer                                                         |
// | Runs write/read phases, drains measurement, snapshots results to CSRs.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_test_sequencer
  import mem_test_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int TMO_W        = 32
) (
  input wire                  clk_i,
  input wire                  rst_i,
  mem_test_sequencer_if.slave bus
);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRN_W-1:0] c_drain_last = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRN_W-1:0] c_drain_full = DRN_W'(DRAIN_CYCLES);

  seq_state_t    r_state, w_next;
  test_mode_t    r_mode;
  test_status_t  r_status, w_exc_status;
  meas_results_t r_result;
  logic [DRN_W-1:0] r_drain;
  logic r_done, r_first, r_stop;
  logic w_run, w_watched, w_drain_met, w_exit, w_exc, w_expire, w_wd_load;

  assign w_run       = (r_state == S_WR_RUN) || (r_state == S_RD_RUN);
  assign w_watched   = w_run || (r_state == S_DRAIN);
  assign w_drain_met = (r_state == S_DRAIN) && !bus.meas_busy_i && (r_drain == c_drain_last);
  assign w_exit      = w_run ? bus.gen_done_i : w_drain_met;
  assign w_wd_load   = ((w_next == S_WR_RUN) || (w_next == S_RD_RUN) || (w_next == S_DRAIN))
                       && (w_next != r_state);

  mem_test_sequencer_seq_watchdog #(.TMO_W(TMO_W)) u_wdog (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_wd_load),
    .i_load_val (bus.csr_timeout_i),
    .i_en       (w_watched),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Priority inside a watched state: error, abort, normal exit, then timeout.
  always_comb begin
    w_next       = r_state;
    w_exc        = 1'b0;
    w_exc_status = ST_OK;
    case (r_state)
      S_IDLE:  if (bus.csr_start_i) w_next = (bus.csr_mode_i == MODE_RSVD) ? S_DONE : S_CLEAR;
      S_CLEAR: w_next = (r_mode == MODE_RD_ONLY) ? S_RD_RUN : S_WR_RUN;
      S_WR_RUN, S_RD_RUN, S_DRAIN: begin
        if (bus.gen_error_i) begin
          w_exc        = 1'b1;
          w_exc_status = ST_GEN_ERR;
        end else if (bus.csr_abort_i) begin
          w_exc        = 1'b1;
          w_exc_status = ST_ABORT;
        end else if (w_exit) begin
          if (r_state == S_DRAIN)                                    w_next = S_SNAP;
          else if (r_state == S_WR_RUN && r_mode == MODE_WR_THEN_RD) w_next = S_RD_RUN;
          else                                                       w_next = S_DRAIN;
        end else if (w_expire) begin
          w_exc        = 1'b1;
          w_exc_status = ST_TIMEOUT;
        end
        if (w_exc) w_next = S_SNAP;
      end
      S_SNAP:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.test_start_o = (r_state == S_CLEAR);
    bus.gen_start_o  = r_first;
    bus.gen_op_o     = (r_state == S_RD_RUN);
    bus.gen_stop_o   = r_stop;
    bus.busy_o       = (r_state != S_IDLE);
    bus.done_o       = r_done;
    bus.status_o     = r_status;
    bus.result_o     = r_result;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mode   <= MODE_WR_ONLY;
      r_status <= ST_OK;
      r_done   <= 1'b0;
      r_first  <= 1'b0;
      r_stop   <= 1'b0;
      r_drain  <= '0;
      r_result <= '0;
    end else begin
      r_first <= ((w_next == S_WR_RUN) || (w_next == S_RD_RUN)) && (w_next != r_state);
      r_stop  <= w_exc && w_run;
      if ((r_state == S_IDLE) && bus.csr_start_i) begin
        r_mode   <= bus.csr_mode_i;
        r_done   <= 1'b0;
        r_status <= (bus.csr_mode_i == MODE_RSVD) ? ST_CFG_ERR : ST_OK;
      end else if (w_exc) begin
        r_status <= w_exc_status;
      end
      if (r_state == S_DONE) r_done <= 1'b1;
      if ((r_state != S_DRAIN) || bus.meas_busy_i) r_drain <= '0;
      else if (r_drain != c_drain_full)            r_drain <= r_drain + 1'b1;
      if (r_state == S_SNAP) r_result <= bus.meas_result_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_test_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_test_sequencer                                                      |
// | Scoreboarded bench: expected completions queued at start, popped on done. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mem_test_sequencer;
  import mem_test_sequencer_pkg::*;

  localparam int TMO_W = 32;

  typedef struct {
    test_status_t  status;
    meas_results_t result;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  mem_test_sequencer_if #(.TMO_W(TMO_W)) bif ();

  mem_test_sequencer #(.DRAIN_CYCLES(4), .TMO_W(TMO_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bif.slave)
  );

  exp_t          sb_q[$];
  int            n_chk   = 0;
  int            n_pass  = 0;
  int            n_done  = 0;
  int            gen_dly = -1;
  meas_results_t last_snap = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bif.gen_start_o;
      1:       return bif.gen_stop_o;
      2:       return !bif.busy_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int budget, output int n);
    n = 0;
    while (!sig(sel) && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (n_done < target && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", n_done, target);
  endtask

  task automatic start(input logic [1:0] mode, input logic [TMO_W-1:0] tmo);
    bif.csr_mode_i    = test_mode_t'(mode);
    bif.csr_timeout_i = tmo;
    bif.csr_start_i   = 1'b1;
    tick();
    bif.csr_start_i   = 1'b0;
  endtask

  task automatic push(input test_status_t st, input meas_results_t res);
    sb_q.push_back('{status: st, result: res});
  endtask

  function automatic meas_results_t mk_res(input logic [31:0] base);
    meas_results_t r;
    for (int i = 0; i < 8; i++) r[i] = base + (32'(i) * 32'h0101_0000);
    return r;
  endfunction

  // Generator model: gen_done gen_dly cycles after each gen_start, dropped on stop/idle.
  initial begin
    int cnt;
    cnt = -1;
    bif.gen_done_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      bif.gen_done_i = 1'b0;
      if (!bif.busy_o || bif.gen_stop_o) cnt = -1;
      else if (bif.gen_start_o)          cnt = gen_dly;
      else if (cnt > 0)                  cnt--;
      if (cnt == 0) begin
        bif.gen_done_i = 1'b1;
        cnt = -1;
      end
    end
  end

  // Completion monitor: every rising done_o consumes one scoreboard entry.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (bif.done_o && !prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", bif.done_o, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("sb_status", bif.status_o, e.status);
          check("sb_result", bif.result_o, e.result);
        end
        n_done++;
      end
      prev = bif.done_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t, want completion earlier", $time);
    $fatal(1);
  end

  initial begin
    int            n;
    int            idle_c;
    meas_results_t p;

    bif.csr_start_i   = 1'b0;
    bif.csr_abort_i   = 1'b0;
    bif.csr_mode_i    = MODE_WR_ONLY;
    bif.csr_timeout_i = '0;
    bif.gen_error_i   = 1'b0;
    bif.meas_busy_i   = 1'b0;
    bif.meas_result_i = '0;

    tick_n(3);
    check("rst_ctrl", {bif.test_start_o, bif.gen_start_o, bif.gen_op_o, bif.gen_stop_o,
                       bif.busy_o, bif.done_o, bif.status_o}, 9'd0);
    check("rst_result", bif.result_o, 256'd0);
    rst_i = 1'b0;
    tick();

    // Write-then-read, no timeout
    p = mk_res(32'h1111_0000); bif.meas_result_i = p; gen_dly = 20;
    push(ST_OK, p); last_snap = p;
    start(2'd2, 0);
    check("t1_clear", {bif.test_start_o, bif.gen_start_o, bif.busy_o}, 3'b101);
    tick();
    check("t1_wr_start", {bif.test_start_o, bif.gen_start_o, bif.gen_op_o}, 3'b010);
    tick();
    wait_sig(0, 40, n);
    check("t1_rd_start_lat", n, 20);
    check("t1_rd_op", {bif.gen_start_o, bif.gen_op_o}, 2'b11);
    wait_done(1, 60);
    bif.meas_result_i = mk_res(32'hDEAD_0000);
    tick_n(3);
    check("t1_done_sticky", {bif.done_o, bif.busy_o}, 2'b10);
    check("t1_result_stable", bif.result_o, p);

    // Write-only, 50-cycle timeout, generator never completes
    p = mk_res(32'h2222_0000); bif.meas_result_i = p; gen_dly = -1;
    push(ST_TIMEOUT, p); last_snap = p;
    start(2'd0, 50);
    check("t2_done_clr", bif.done_o, 1'b0);
    tick();
    check("t2_wr_start", bif.gen_start_o, 1'b1);
    wait_sig(1, 80, n);
    check("t2_stop_lat", n, 50);
    tick();
    check("t2_stop_pulse", bif.gen_stop_o, 1'b0);
    wait_done(2, 10);

    // Read-only, abort 10 cycles into the phase
    p = mk_res(32'h3333_0000); bif.meas_result_i = p; gen_dly = -1;
    push(ST_ABORT, p); last_snap = p;
    start(2'd1, 0);
    tick();
    check("t3_rd_start", {bif.gen_start_o, bif.gen_op_o}, 2'b11);
    tick_n(10);
    bif.csr_abort_i = 1'b1;
    tick();
    bif.csr_abort_i = 1'b0;
    check("t3_stop", bif.gen_stop_o, 1'b1);
    wait_sig(2, 4, n);
    check("t3_idle_lat", n, 2);
    wait_done(3, 4);

    // Drain with busy 1-0-0-0-1 then low; snapshot taken in the cycle after 4 quiet cycles
    gen_dly = 3;
    p = mk_res(32'h4444_0000 + 32'd13);
    push(ST_OK, p); last_snap = p;
    start(2'd0, 0);
    tick();
    idle_c = -1;
    for (int c = 0; c < 24; c++) begin
      bif.meas_result_i = mk_res(32'h4444_0000 + 32'(c));
      bif.meas_busy_i   = (c == 4) || (c == 8);
      if (!bif.busy_o && idle_c < 0) idle_c = c;
      tick();
    end
    bif.meas_busy_i = 1'b0;
    check("t4_idle_cycle", idle_c, 15);
    wait_done(4, 2);

    // gen_done in the expiry cycle wins
    p = mk_res(32'h5A5A_0000); bif.meas_result_i = p; gen_dly = 4;
    push(ST_OK, p); last_snap = p;
    start(2'd0, 5);
    tick();
    wait_done(5, 40);

    // gen_done one cycle late loses to the timeout
    p = mk_res(32'h5B5B_0000); bif.meas_result_i = p; gen_dly = 5;
    push(ST_TIMEOUT, p); last_snap = p;
    start(2'd0, 5);
    tick();
    wait_sig(1, 20, n);
    check("t5b_stop_lat", n, 5);
    wait_done(6, 10);

    // gen_error and gen_done together: error wins
    p = mk_res(32'h5C5C_0000); bif.meas_result_i = p; gen_dly = 6;
    push(ST_GEN_ERR, p); last_snap = p;
    start(2'd0, 0);
    tick();
    tick_n(6);
    bif.gen_error_i = 1'b1;
    tick();
    bif.gen_error_i = 1'b0;
    check("t5c_stop", bif.gen_stop_o, 1'b1);
    wait_done(7, 10);

    // Reserved mode: config error, previous snapshot kept
    bif.meas_result_i = mk_res(32'h6666_0000);
    push(ST_CFG_ERR, last_snap);
    start(2'd3, 0);
    check("t6_cfg_done_state", {bif.busy_o, bif.done_o, bif.status_o}, {2'b10, ST_CFG_ERR});
    tick();
    check("t6_cfg_done", {bif.busy_o, bif.done_o}, 2'b01);
    wait_done(8, 2);

    // Start while busy is ignored (its mode must not be latched)
    p = mk_res(32'h6767_0000); bif.meas_result_i = p; gen_dly = 10;
    push(ST_OK, p); last_snap = p;
    start(2'd0, 0);
    tick();
    tick_n(3);
    bif.csr_mode_i  = MODE_WR_THEN_RD;
    bif.csr_start_i = 1'b1;
    tick();
    bif.csr_start_i = 1'b0;
    wait_sig(2, 40, n);
    check("t6_busy_start_idle", n, 13);
    wait_done(9, 4);

    // Asynchronous reset in the middle of a read phase
    gen_dly = -1;
    start(2'd1, 0);
    tick_n(4);
    check("t6_pre_rst_op", bif.gen_op_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_rst_ctrl", {bif.test_start_o, bif.gen_start_o, bif.gen_op_o, bif.gen_stop_o,
                          bif.busy_o, bif.done_o, bif.status_o}, 9'd0);
    check("t6_rst_result", bif.result_o, 256'd0);
    tick_n(2);
    rst_i = 1'b0;
    tick_n(5);
    check("t6_idle_after_rst", bif.busy_o, 1'b0);
    check("sb_drained", sb_q.size(), 0);
    check("done_total", n_done, 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
